// File: rtl/usb3300_pkg.sv
// Shared types and constants for the USB3300 ULPI receive-side decoder.
package usb3300_pkg;

   localparam int ULPI_W        = 8;
   localparam int MAX_PKT_BYTES = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TURN = 2'd1,
      RECV = 2'd2
   } state_t;

endpackage

// File: rtl/usb3300_receiver_if.sv
// ULPI receive bundle: PHY-side inputs plus the decoded capture outputs.
interface usb3300_receiver_if;
   import usb3300_pkg::*;

   logic              DIR;
   logic              NXT;
   logic [ULPI_W-1:0] DATA;
   logic              ME;
   logic [ULPI_W-1:0] PID;
   logic [ULPI_W-1:0] D1;
   logic [ULPI_W-1:0] D2;
   logic [ULPI_W-1:0] CMD;
   logic              NP;
   logic              busy;

   // PHY / stimulus side
   modport master (
      output DIR, NXT, DATA, ME,
      input  PID, D1, D2, CMD, NP, busy
   );

   // Decoder side
   modport slave (
      input  DIR, NXT, DATA, ME,
      output PID, D1, D2, CMD, NP, busy
   );

endinterface

// File: rtl/usb3300_receiver.sv
// ULPI RX decoder: drops turnaround, splits RX CMD vs packet bytes, latches PID/D1/D2/CMD.
// Outputs registered (visible one edge after sampling); passive sniffer, no backpressure.
module usb3300_receiver
   import usb3300_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   usb3300_receiver_if.slave  bus
);

   localparam logic [1:0] CNT_MAX = 2'(MAX_PKT_BYTES);

   state_t            r_state;
   logic [1:0]        r_cnt;
   logic [ULPI_W-1:0] r_pid;
   logic [ULPI_W-1:0] r_d1;
   logic [ULPI_W-1:0] r_d2;
   logic [ULPI_W-1:0] r_cmd;
   logic              r_np;
   logic              r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
         r_pid   <= '0;
         r_d1    <= '0;
         r_d2    <= '0;
         r_cmd   <= '0;
         r_np    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_np <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.DIR && bus.ME) begin
                  r_state <= TURN;
                  r_busy  <= 1'b1;
               end
            end
            TURN: begin
               if (!bus.DIR) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= RECV;
                  r_cnt   <= 2'd0;
               end
            end
            RECV: begin
               if (!bus.DIR) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_np    <= (r_cnt != 2'd0);
               end else if (!bus.NXT) begin
                  r_cmd <= bus.DATA;
               end else begin
                  // D1/D2 clear with the PID so CMD-only bursts leave the last packet intact
                  case (r_cnt)
                     2'd0: begin
                        r_pid <= bus.DATA;
                        r_d1  <= '0;
                        r_d2  <= '0;
                     end
                     2'd1:    r_d1 <= bus.DATA;
                     2'd2:    r_d2 <= bus.DATA;
                     default: ;
                  endcase
                  if (r_cnt != CNT_MAX) begin
                     r_cnt <= r_cnt + 2'd1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.PID  = r_pid;
   assign bus.D1   = r_d1;
   assign bus.D2   = r_d2;
   assign bus.CMD  = r_cmd;
   assign bus.NP   = r_np;
   assign bus.busy = r_busy;

endmodule

// File: tb/tb_usb3300_receiver.sv
// Randomized bench for usb3300_receiver against a burst-level reference model.
module tb_usb3300_receiver;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   usb3300_receiver_if bus();

   usb3300_receiver dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Expected capture registers, updated per burst by the model
   logic [7:0] e_pid = 8'h00;
   logic [7:0] e_d1  = 8'h00;
   logic [7:0] e_d2  = 8'h00;
   logic [7:0] e_cmd = 8'h00;

   logic       b_nxt [16];
   logic [7:0] b_dat [16];

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic set_b(input int i, input logic nxt, input logic [7:0] dat);
      b_nxt[i] = nxt;
      b_dat[i] = dat;
   endtask

   task automatic step(input logic dir, input logic nxt, input logic [7:0] dat, input logic me,
                       input logic exp_busy, input logic exp_np);
      @(negedge clk);
      bus.DIR  = dir;
      bus.NXT  = nxt;
      bus.DATA = dat;
      bus.ME   = me;
      @(posedge clk);
      #1;
      chk("busy", 8'(bus.busy), 8'(exp_busy));
      chk("np",   8'(bus.NP),   8'(exp_np));
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_pid"}, bus.PID, e_pid);
      chk({tag, "_d1"},  bus.D1,  e_d1);
      chk({tag, "_d2"},  bus.D2,  e_d2);
      chk({tag, "_cmd"}, bus.CMD, e_cmd);
   endtask

   // Drive one DIR-high burst of len cycles then gap DIR-low cycles.
   // Model: first two bytes of an accepted burst are turnaround; of the rest,
   // NXT=0 bytes are RX CMDs and NXT=1 bytes form the packet.
   task automatic burst(input int len, input logic me0, input int gap, input string tag);
      logic [7:0] pk[$];
      logic       acc;
      logic       exp_np;
      logic       me;
      acc    = me0;
      exp_np = 1'b0;
      for (int i = 0; i < len; i++) begin
         me = (i == 0 || !acc) ? me0 : 1'($urandom_range(0, 1));
         step(1'b1, b_nxt[i], b_dat[i], me, acc, 1'b0);
      end
      if (acc && len >= 2) begin
         for (int i = 2; i < len; i++) begin
            if (!b_nxt[i]) e_cmd = b_dat[i];
            else pk.push_back(b_dat[i]);
         end
         if (pk.size() > 0) begin
            e_pid  = pk[0];
            e_d1   = (pk.size() > 1) ? pk[1] : 8'h00;
            e_d2   = (pk.size() > 2) ? pk[2] : 8'h00;
            exp_np = 1'b1;
         end
      end
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           1'b0, exp_np);
      check_regs(tag);
      for (int i = 1; i < gap; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              1'b0, 1'b0);
      end
   endtask

   task automatic load_token();
      set_b(0, 1'b0, 8'h41);
      set_b(1, 1'b0, 8'h42);
      set_b(2, 1'b1, 8'h43);
      set_b(3, 1'b1, 8'h44);
      set_b(4, 1'b0, 8'h42);
      set_b(5, 1'b1, 8'h45);
   endtask

   initial begin
      clk      = 1'b0;
      rst_n    = 1'b0;
      bus.DIR  = 1'b0;
      bus.NXT  = 1'b0;
      bus.DATA = 8'h00;
      bus.ME   = 1'b1;
      #12;
      check_regs("rst");
      chk("rst_busy", 8'(bus.busy), 8'h00);
      chk("rst_np",   8'(bus.NP),   8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Token burst
      load_token();
      burst(6, 1'b1, 2, "tok");
      chk("tok_pid_c", bus.PID, 8'h43);
      chk("tok_d1_c",  bus.D1,  8'h44);
      chk("tok_d2_c",  bus.D2,  8'h45);
      chk("tok_cmd_c", bus.CMD, 8'h42);

      // RX CMD only: packet registers untouched, no NP
      set_b(0, 1'b0, 8'h11);
      set_b(1, 1'b0, 8'h22);
      set_b(2, 1'b0, 8'h4D);
      burst(3, 1'b1, 2, "cmd");
      chk("cmd_cmd_c", bus.CMD, 8'h4D);
      chk("cmd_d1_c",  bus.D1,  8'h44);

      // Short packet
      set_b(0, 1'b0, 8'h11);
      set_b(1, 1'b0, 8'h22);
      set_b(2, 1'b1, 8'hD2);
      burst(3, 1'b1, 2, "short");
      chk("short_pid_c", bus.PID, 8'hD2);
      chk("short_d1_c",  bus.D1,  8'h00);
      chk("short_d2_c",  bus.D2,  8'h00);

      // Long packet: bytes past the third are ignored
      set_b(0, 1'b0, 8'h11);
      set_b(1, 1'b0, 8'h22);
      for (int i = 0; i < 5; i++) set_b(i + 2, 1'b1, 8'(i + 1));
      burst(7, 1'b1, 2, "long");
      chk("long_pid_c", bus.PID, 8'h01);
      chk("long_d1_c",  bus.D1,  8'h02);
      chk("long_d2_c",  bus.D2,  8'h03);

      // Module disabled: burst ignored
      load_token();
      burst(6, 1'b0, 2, "me0");
      chk("me0_pid_c", bus.PID, 8'h01);

      // Back-to-back bursts with a single DIR-low cycle
      load_token();
      burst(6, 1'b1, 1, "b2b_a");
      set_b(0, 1'b0, 8'h00);
      set_b(1, 1'b1, 8'h99);
      set_b(2, 1'b1, 8'hA5);
      set_b(3, 1'b0, 8'h3C);
      set_b(4, 1'b1, 8'h5A);
      burst(5, 1'b1, 2, "b2b_b");
      chk("b2b_pid_c", bus.PID, 8'hA5);
      chk("b2b_d1_c",  bus.D1,  8'h5A);
      chk("b2b_cmd_c", bus.CMD, 8'h3C);

      // Asynchronous reset mid-burst
      load_token();
      step(1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h42, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      e_pid = 8'h00;
      e_d1  = 8'h00;
      e_d2  = 8'h00;
      e_cmd = 8'h00;
      check_regs("arst");
      chk("arst_busy", 8'(bus.busy), 8'h00);
      chk("arst_np",   8'(bus.NP),   8'h00);
      bus.DIR = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized bursts
      for (int n = 0; n < 60; n++) begin
         int   len;
         logic me0;
         len = $urandom_range(1, 10);
         me0 = ($urandom_range(0, 4) != 0);
         for (int i = 0; i < len; i++) begin
            set_b(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         end
         burst(len, me0, $urandom_range(1, 3), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
